// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, controller states, flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SRL  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_SRA  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_MULH = 4'b1001,
    OP_DIVU = 4'b1010,
    OP_REMU = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_SLTU = 4'b1101,
    OP_RSV0 = 4'b1110,
    OP_RSV1 = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic dz;
  } alu_flags_t;

  // mul/mulh/divu/remu all live in the 10xx block
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unit: WIDTH-step shift-add multiplier and restoring divider.
// o_done/o_res are combinational on the final step so the parent can register them.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_kind,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res,
  output logic             o_dz
);
  localparam int SHW = $clog2(WIDTH);

  logic                 r_busy;
  logic [SHW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opd;
  logic [1:0]           r_kind;
  logic                 r_neg;

  logic [WIDTH-1:0]     w_a_mag, w_b_mag;
  logic [WIDTH:0]       w_madd, w_rem, w_rsub;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_nxt, w_prod;

  // mulh works on magnitudes; mul's low half is sign-agnostic so it uses raw bits
  assign w_a_mag = (i_kind == 2'b01 && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag = (i_kind == 2'b01 && i_b[WIDTH-1]) ? -i_b : i_b;

  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

  // partial remainder stays below the divisor, so WIDTH+1 bits suffice
  assign w_rem     = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_rsub    = w_rem - {1'b0, r_opd};
  assign w_div_nxt = w_rsub[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                   : {w_rsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_nxt  = r_kind[1] ? w_div_nxt : w_mul_nxt;
  assign w_prod = r_neg ? -w_nxt : w_nxt;

  assign o_done = r_busy && (r_cnt == SHW'(WIDTH - 1));
  assign o_dz   = r_kind[1] && (r_opd == '0);

  always_comb begin
    o_res = w_nxt[WIDTH-1:0];
    case (r_kind)
      2'b00:   o_res = w_nxt[WIDTH-1:0];
      2'b01:   o_res = w_prod[2*WIDTH-1:WIDTH];
      2'b10:   o_res = w_nxt[WIDTH-1:0];
      default: o_res = w_nxt[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opd  <= '0;
      r_kind <= 2'b00;
      r_neg  <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_kind <= i_kind;
      r_neg  <= (i_kind == 2'b01) && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      if (i_kind[1]) begin
        r_acc <= {{WIDTH{1'b0}}, i_a};
        r_opd <= i_b;
      end else begin
        r_acc <= {{WIDTH{1'b0}}, w_b_mag};
        r_opd <= w_a_mag;
      end
    end else if (r_busy) begin
      r_acc <= w_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and flags; single-cycle ops plus
// multi-cycle mul/div delegated to alu_muldiv.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       r_state;
  logic [WIDTH-1:0] r_out;
  alu_flags_t       r_flags;

  alu_op_e          w_op;
  logic             w_accept, w_is_md;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;
  alu_flags_t       w_sc_flags, w_md_flags;
  logic             w_md_done, w_md_dz;
  logic [WIDTH-1:0] w_md_res;

  assign w_op     = alu_op_e'(op);
  assign in_ready = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_md  = is_muldiv(op);
  assign w_sh     = b[SHW-1:0];
  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_diff   = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_res = a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  w_res = a << w_sh;
      OP_SRL:  w_res = a >> w_sh;
      OP_SRA:  w_res = WIDTH'($signed(a) >>> w_sh);
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, a < b};
      default: w_res = a;
    endcase
  end

  assign w_sc_flags = '{z: (w_res == '0), n: w_res[WIDTH-1], c: w_c, v: w_v, dz: 1'b0};
  assign w_md_flags = '{z: (w_md_res == '0), n: w_md_res[WIDTH-1], c: 1'b0, v: 1'b0, dz: w_md_dz};

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_is_md),
    .i_kind  (op[1:0]),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_md_done),
    .o_res   (w_md_res),
    .o_dz    (w_md_dz)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      if (w_is_md) begin
        r_state <= BUSY;
      end else begin
        r_state <= DONE;
        r_out   <= w_res;
        r_flags <= w_sc_flags;
      end
    end else if (r_state == DONE && out_ready) begin
      r_state <= IDLE;
    end else if (r_state == BUSY && w_md_done) begin
      r_state <= DONE;
      r_out   <= w_md_res;
      r_flags <= w_md_flags;
    end
  end

  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign flag_z    = r_flags.z;
  assign flag_n    = r_flags.n;
  assign flag_c    = r_flags.c;
  assign flag_v    = r_flags.v;
  assign flag_dz   = r_flags.dz;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results, flags, latency and handshake.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, out;
  logic [3:0]  op;
  logic        flag_z, flag_n, flag_c, flag_v, flag_dz;
  logic [4:0]  fl;

  int n_err = 0;
  int n_chk = 0;

  assign fl = {flag_z, flag_n, flag_c, flag_v, flag_dz};

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb);
    in_valid = 1'b1; op = o; a = xa; b = xb;
    #1;
    chk("in_ready_before_issue", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic sc(input string tag, input logic [3:0] o, input logic [31:0] xa,
                    input logic [31:0] xb, input logic [31:0] exp, input logic [4:0] ef);
    issue(o, xa, xb);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_out"}, 64'(out), 64'(exp));
    chk({tag, "_flags"}, 64'(fl), 64'(ef));
    consume();
  endtask

  task automatic md(input string tag, input logic [3:0] o, input logic [31:0] xa,
                    input logic [31:0] xb, input logic [31:0] exp, input logic [4:0] ef,
                    input bit keep);
    int lat;
    issue(o, xa, xb);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_out"}, 64'(out), 64'(exp));
    chk({tag, "_flags"}, 64'(fl), 64'(ef));
    if (!keep) consume();
  endtask

  initial begin
    int sent, rcv, cyc;
    bit hold;
    logic [31:0] held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_flags", 64'(fl), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // flags packed as {z,n,c,v,dz}
    sc("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b01010);
    sc("sub_brw",  4'b0001, 32'h0, 32'h1, 32'hFFFF_FFFF, 5'b01100);
    sc("add_cz",   4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b10100);
    sc("sra",      4'b0101, 32'h8000_0000, 32'h21, 32'hC000_0000, 5'b01000);
    sc("srl",      4'b0011, 32'h8000_0000, 32'h21, 32'h4000_0000, 5'b00000);
    sc("sll_max",  4'b0010, 32'h1, 32'h1F, 32'h8000_0000, 5'b01000);
    sc("sll_zero", 4'b0010, 32'h1234, 32'h20, 32'h1234, 5'b00000);
    sc("and",      4'b0100, 32'hF0F0, 32'hFF00, 32'hF000, 5'b00000);
    sc("or",       4'b0110, 32'hF0F0, 32'h0F00, 32'hFFF0, 5'b00000);
    sc("xor",      4'b0111, 32'hFFFF, 32'hFFFF, 32'h0, 5'b10000);
    sc("slt",      4'b1100, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00000);
    sc("sltu",     4'b1101, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b10000);
    sc("rsv",      4'b1110, 32'hDEAD_BEEF, 32'h5, 32'hDEAD_BEEF, 5'b01000);

    md("mulh_neg", 4'b1001, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 5'b01000, 1'b0);
    md("mulh_big", 4'b1001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'b00000, 1'b0);
    md("divu",     4'b1010, 32'd100, 32'd7, 32'd14, 5'b00000, 1'b0);
    md("remu",     4'b1011, 32'd100, 32'd7, 32'd2, 5'b00000, 1'b0);
    md("divu_dz",  4'b1010, 32'd100, 32'd0, 32'hFFFF_FFFF, 5'b01001, 1'b0);
    md("remu_dz",  4'b1011, 32'h1234, 32'd0, 32'h1234, 5'b00001, 1'b0);
    md("mul",      4'b1000, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFF1, 5'b01000, 1'b1);

    // result must hold under backpressure, even with new inputs wiggling
    in_valid = 1'b1; a = 32'h5; b = 32'h5; op = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_out", 64'(out), 64'hFFFF_FFF1);
    end
    in_valid = 1'b0;
    consume();

    // reset during a multiply discards it
    issue(4'b1000, 32'h3, 32'h5);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", 64'(out), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (40) tick();
    chk("midrst_no_stale", 64'(out_valid), 64'd0);

    // back-to-back adds, one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = 4'b0000; a = 32'(i); b = 32'd100;
      tick();
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_out", 64'(out), 64'(i + 100));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    // random backpressure stream: in order, no drops, stable while stalled
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 8 && cyc < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      op = 4'b0000; a = 32'(sent * 3 + 1); b = 32'h10;
      #1;
      if (out_valid && out_ready) begin
        chk("bp_out", 64'(out), 64'(rcv * 3 + 1 + 16));
        rcv++;
      end
      hold = out_valid && !out_ready;
      held = out;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      if (hold) begin
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_out", 64'(out), 64'(held));
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_count", 64'(rcv), 64'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's combinational 32-bit ALU. It registers every result, adds condition flags, and adds iterative multiply/divide through an internal multi-cycle unit. It sits between the decode/operand-fetch stage and writeback, with valid/ready on both sides so the pipeline can stall on long operations.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 8, power of two).
- SHW, $clog2(WIDTH), derived localparam: shift-amount width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A (signed for signed ops).
- b  in  WIDTH  operand B.
- op  in  4  operation code, see Operation.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  result.
- flag_z, flag_n, flag_c, flag_v, flag_dz  out  1 each  zero, negative, carry/borrow, signed overflow, divide-by-zero.

## Operation
- Op codes:
  - 0000 add, 0001 sub, 0010 sll, 0011 srl, 0100 and, 0101 sra, 0110 or, 0111 xor. The low eight codes keep the legacy encoding.
  - 1000 mul (low WIDTH bits), 1001 mulh (signed high WIDTH bits), 1010 divu (quotient), 1011 remu (remainder).
  - 1100 slt (signed a<b → 1, else 0), 1101 sltu (unsigned).
  - 1110/1111 reserved: out = a.
- Shifts use b[SHW-1:0] only; upper bits of b are ignored.
- Flags:
  - flag_z = (out == 0) and flag_n = out[WIDTH-1], both for every op.
  - flag_c = carry-out on add; borrow (a < b unsigned) on sub; 0 otherwise.
  - flag_v = signed overflow on add/sub; 0 otherwise.
  - flag_dz = 1 only for divu/remu with b == 0.
- Divide by zero: quotient all-ones, remainder = a. There is no exception.
- mulh: form magnitudes, multiply unsigned, negate the 2·WIDTH product if signs differ, take the upper half.
- FSM:
  - IDLE: in_ready = 1. On accept with a single-cycle op → DONE. On accept with op 10xx → BUSY.
  - BUSY: in_ready = 0. Iteration counter runs 0..WIDTH-1. When the counter reaches WIDTH-1 → DONE.
  - DONE: out_valid = 1; out and flags are stable. out_ready=1 with in_valid=0 → IDLE. out_ready=1 with in_valid=1 → accept the new op directly (→ DONE or BUSY).
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- a, b and op are captured on accept (in_valid & in_ready). Changes to inputs while in BUSY or DONE are ignored.

## Timing
- Reset (rst_n = 0 at a clk edge): state IDLE, out_valid 0, out 0, all flags 0, counter 0, in_ready 1 from the next cycle. Reset in BUSY aborts the operation and no result is produced.
- Single-cycle ops: accept at edge N → out_valid high after edge N, visible in cycle N+1.
- mul/mulh/divu/remu: accept at edge N → out_valid visible in cycle N+WIDTH+1. Latency is data-independent, including divide by zero.
- Back-to-back single-cycle ops with out_ready held 1 sustain one result per cycle.
- Holding out_ready = 0 keeps out, flags and out_valid unchanged indefinitely.
- Shift amount 0 → out = a. Shift amount WIDTH-1 → full-range shift, no wrap.

## Structure
- Package alu_pkg holds:
  - the op enum (4-bit, names as listed above);
  - the FSM state enum (IDLE, BUSY, DONE);
  - the flag struct {z, n, c, v, dz}.
- Sub-module alu_muldiv holds the iterative unit:
  - shift-add multiplier and restoring divider;
  - start/done handshake with the parent;
  - owns the iteration counter and the 2·WIDTH accumulator.
- The parent holds the FSM, the single-cycle datapath, flag generation and the output registers.

## Test plan
- Reset mid-op: start mul, drop rst_n at cycle 5 → out_valid 0, out 0, in_ready 1 after release, no stale result.
- Add overflow: add a=0x7FFFFFFF, b=1 → out 0x80000000, flag_n=1, flag_v=1, flag_c=0, one-cycle latency. Sub a=0, b=1 → 0xFFFFFFFF, flag_c=1.
- Shifts: sra a=0x80000000, b=0x21 → out 0xC0000000 (amount 1). srl same operands → 0x40000000.
- Multiply: mulh a=-3, b=5 → out 0xFFFFFFFF. mul a=-3, b=5 → 0xFFFFFFF1. out_valid exactly 33 cycles after accept.
- Divide: divu a=100, b=7 → 14. remu → 2. divu b=0 → out 0xFFFFFFFF, flag_dz=1, latency still 33.
- Backpressure: stream 8 adds with out_ready toggling randomly → results in order, none dropped or duplicated, outputs stable while out_ready = 0. With out_ready held 1 → 8 results in 8 consecutive cycles.
